// File: rtl/serial_add_arbiter.sv
// ---------------------------------------------------------------------------
// serial_add_arbiter
//
// Purpose:
//    Two requesters share one bit-serial adder. The winner of arbitration is
//    granted for a whole operation: its operands are captured, added one bit
//    per clock (LSB first), and the N-bit sum plus carry-out are presented
//    with a one-cycle done pulse.
//
//    Operation timeline for a request sampled in IDLE at cycle t:
//       t+1          LOAD  (grant visible, operands captured)
//       t+2..t+N+1   ADD   (one sum bit per cycle)
//       t+N+2        DONE  (done=1, done_id, sum/cout valid)
//    The FSM always passes through IDLE afterwards, so the period is N+3.
//
// Configuration:
//    SERIAL_ARB_RR_EN  defined   -> round-robin arbitration between requesters
//                      undefined -> fixed priority, requester 0 always wins
//
// Parameters:
//    N        operand / sum width in bits (N >= 2)
//
// Ports:
//    clk      single clock, all registers update on its rising edge
//    rst      synchronous, active-low reset
//    req0/1   addition requests from requester 0 / 1
//    a0,b0    operands of requester 0
//    a1,b1    operands of requester 1
//    gnt0/1   registered grants, one-hot or zero, high from LOAD to DONE
//    busy     high while an operation is in LOAD, ADD or DONE
//    done     one-cycle completion pulse (DONE state)
//    done_id  requester index of the completed operation, valid with done
//    sum      result of the last completed addition
//    cout     carry-out of the last completed addition
// ---------------------------------------------------------------------------
module serial_add_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [N-1:0] a0,
   input  logic [N-1:0] b0,
   input  logic [N-1:0] a1,
   input  logic [N-1:0] b1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         busy,
   output logic         done,
   output logic         done_id,
   output logic [N-1:0] sum,
   output logic         cout
);

   // Bit counter must be able to hold N-1 (last ADD cycle) for any N >= 2.
   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_q,   state_d;
   logic            gnt0_q,    gnt0_d;
   logic            gnt1_q,    gnt1_d;
   logic [N-1:0]    a_sh_q,    a_sh_d;     // operand A shift register
   logic [N-1:0]    b_sh_q,    b_sh_d;     // operand B shift register
   logic [N-1:0]    acc_q,     acc_d;      // sum bits collected MSB-first
   logic            carry_q,   carry_d;
   logic [CW-1:0]   cnt_q,     cnt_d;
   logic [N-1:0]    sum_q,     sum_d;
   logic            cout_q,    cout_d;
   logic            done_id_q, done_id_d;

   // Arbitration result: 1 selects requester 1, 0 selects requester 0.
   // Only meaningful when at least one request is present.
   logic            pick1;

   // One full-adder slice of the serial datapath.
   logic            bit_s;
   logic            bit_c;

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
`ifdef SERIAL_ARB_RR_EN
   // Index of the requester served most recently. It starts at 1 so the very
   // first contested request goes to requester 0.
   logic            last_q, last_d;

   always_comb begin
      last_d = last_q;
      // The grant registers already hold the winner during LOAD.
      if (state_q == LOAD) begin
         last_d = gnt1_q;
      end
   end

   always_comb begin
      if (req0 && req1) begin
         pick1 = ~last_q;
      end else begin
         pick1 = req1 & ~req0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority: requester 0 wins whenever it asks.
   assign pick1 = req1 & ~req0;
`endif

   // ------------------------------------------------------------------------
   // Serial full adder on the current LSBs
   // ------------------------------------------------------------------------
   assign bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign bit_c = (a_sh_q[0] & b_sh_q[0]) |
                  (a_sh_q[0] & carry_q)   |
                  (b_sh_q[0] & carry_q);

   // ------------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      gnt0_d    = gnt0_q;
      gnt1_d    = gnt1_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      acc_d     = acc_q;
      carry_d   = carry_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      done_id_d = done_id_q;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d = LOAD;
               gnt0_d  = ~pick1;
               gnt1_d  = pick1;
            end
         end

         LOAD: begin
            // Operands are captured here; later changes on a*/b* are ignored.
            a_sh_d  = gnt1_q ? a1 : a0;
            b_sh_d  = gnt1_q ? b1 : b0;
            carry_d = 1'b0;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = ADD;
         end

         ADD: begin
            acc_d   = {bit_s, acc_q[N-1:1]};
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = bit_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               // The final bit lands directly in the visible result so that
               // sum/cout change exactly when DONE is entered.
               state_d   = DONE;
               sum_d     = {bit_s, acc_q[N-1:1]};
               cout_d    = bit_c;
               done_id_d = gnt1_q;
            end
         end

         DONE: begin
            state_d = IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         acc_q     <= '0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         done_id_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         acc_q     <= acc_d;
         carry_q   <= carry_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         done_id_q <= done_id_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign done_id = done_id_q;
   assign sum     = sum_q;
   assign cout    = cout_q;

endmodule
